// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Purpose  : Parallel-side handshake and serial outputs of the UART
//             transmitter, bundled so producer and core share one port.
//  Signals  : p_data      word to transmit
//             data_valid  p_data valid; taken only while busy is low
//             par_enable  insert a parity bit after the data bits
//             par_type    0 = even parity, 1 = odd parity
//             prescale    clk cycles per bit (0 behaves as 1)
//             tx_out      serial line, idle high
//             busy        high while a frame is in progress
//  Modports : master = word producer, slave = transmitter core
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_enable;
    logic                      par_type;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      tx_out;
    logic                      busy;

    modport master (
        output p_data, data_valid, par_enable, par_type, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_enable, par_type, prescale,
        output tx_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_core
//  Purpose  : UART serial transmitter. Sends start bit, DATA_WIDTH data bits
//             LSB first, optional parity bit and one stop bit, each held for
//             a latched number of clk cycles. One frame in flight, no queue.
//  Ports    : clk  system clock, rising edge
//             rst  asynchronous active-high reset
//             bus  uart_tx_if slave (p_data/data_valid/par_*/prescale in,
//                  tx_out/busy out)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_tx_if.slave   bus
);
    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [PRESCALE_WIDTH-1:0] c_PS_ONE   = PRESCALE_WIDTH'(1);
    localparam logic [c_IDX_W-1:0]        c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0]        c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [c_IDX_W-1:0]        r_bit_idx;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_par_bit;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_tx_out;
    logic                      r_busy;

    logic [2:0]                w_state_next;
    logic [PRESCALE_WIDTH-1:0] w_cnt_next;
    logic [c_IDX_W-1:0]        w_bit_idx_next;
    logic                      w_tx_next;
    logic                      w_busy_next;
    logic                      w_accept;
    logic                      w_last;

    assign w_accept = (r_state == c_IDLE) && bus.data_valid;
    // Bit period ends on the edge where the counter sits at P-1.
    assign w_last   = (r_cnt == (r_prescale - c_PS_ONE));

    // ------------------------------------------------------------------
    // State register and frame datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_prescale <= c_PS_ONE;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx_out  <= w_tx_next;
            r_busy    <= w_busy_next;
            // Frame settings are captured only here; later input changes
            // cannot disturb the frame in flight.
            if (w_accept) begin
                r_data     <= bus.p_data;
                r_par_en   <= bus.par_enable;
                r_par_bit  <= bus.par_type ? ~^bus.p_data : ^bus.p_data;
                r_prescale <= (bus.prescale == '0) ? c_PS_ONE : bus.prescale;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_cnt_next     = '0;
        if (r_state != c_IDLE) begin
            w_cnt_next = w_last ? '0 : (r_cnt + c_PS_ONE);
        end
        case (r_state)
            c_IDLE: begin
                if (bus.data_valid) begin
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_last) begin
                    w_state_next   = c_DATA;
                    w_bit_idx_next = '0;
                end
            end
            c_DATA: begin
                if (w_last) begin
                    if (r_bit_idx == c_LAST_IDX) begin
                        w_state_next = r_par_en ? c_PARITY : c_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + c_IDX_ONE;
                    end
                end
            end
            c_PARITY: begin
                if (w_last) begin
                    w_state_next = c_STOP;
                end
            end
            c_STOP: begin
                if (w_last) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the upcoming state so that tx_out and
    // busy come straight from flops and change together with the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        case (w_state_next)
            c_START: begin
                w_tx_next   = 1'b0;
                w_busy_next = 1'b1;
            end
            c_DATA: begin
                w_tx_next   = r_data[w_bit_idx_next];
                w_busy_next = 1'b1;
            end
            c_PARITY: begin
                w_tx_next   = r_par_bit;
                w_busy_next = 1'b1;
            end
            c_STOP: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            default: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_core
//  Purpose  : Directed self-checking bench for uart_tx_core. Each frame is
//             captured cycle by cycle and compared with a hand-written bit
//             sequence stretched to the bit period.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) bus ();

    uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present a word for one accepting edge; returns at the sample point
    // just after that edge. With hold set, data_valid stays high.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptype,
                               input logic [7:0] ps, input bit hold);
        @(negedge clk);
        bus.p_data     = d;
        bus.par_enable = pen;
        bus.par_type   = ptype;
        bus.prescale   = ps;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.data_valid = 1'b0;
    endtask

    // Sample tx_out once per cycle while busy is high. fbits holds the frame
    // bits in send order (bit 0 = start bit). With mid_pulse, the inputs are
    // disturbed and a stray data_valid is pulsed partway through the frame.
    task automatic capture(input string tag, input logic [15:0] fbits, input int nbits,
                           input int p, input bit mid_pulse);
        logic [127:0] obs;
        logic [127:0] exp;
        int n;
        obs = '0;
        exp = '0;
        n   = 0;
        for (int i = 0; i < nbits * p; i++) exp[i] = fbits[i / p];
        while (bus.busy === 1'b1 && n < 120) begin
            obs[n] = bus.tx_out;
            if (mid_pulse && n == 10) begin
                bus.p_data     = 8'hFF;
                bus.prescale   = 8'd1;
                bus.par_enable = 1'b0;
                bus.data_valid = 1'b1;
            end
            if (mid_pulse && n == 11) bus.data_valid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_len"}, 128'(n), 128'(nbits * p));
        check({tag, "_wave"}, obs, exp);
        check({tag, "_idle_tx"}, 128'(bus.tx_out), 128'(1));
    endtask

    initial begin
        int bad;
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_enable = 1'b0;
        bus.par_type   = 1'b0;
        bus.prescale   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 128'(bus.tx_out), 128'(1));
        check("reset_busy", 128'(bus.busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // D2, even parity (0), P=4 -> 44 clk
        start_frame(8'hD2, 1'b1, 1'b0, 8'd4, 1'b0);
        capture("d2_even", {5'b0, 1'b1, 1'b0, 8'hD2, 1'b0}, 11, 4, 1'b0);

        // D2, odd parity (1), P=4 -> 44 clk
        start_frame(8'hD2, 1'b1, 1'b1, 8'd4, 1'b0);
        capture("d2_odd", {5'b0, 1'b1, 1'b1, 8'hD2, 1'b0}, 11, 4, 1'b0);

        // D2, no parity, P=4 -> 40 clk
        start_frame(8'hD2, 1'b0, 1'b0, 8'd4, 1'b0);
        capture("d2_nopar", {6'b0, 1'b1, 8'hD2, 1'b0}, 10, 4, 1'b0);

        // prescale 0 behaves as 1
        start_frame(8'h55, 1'b0, 1'b0, 8'd0, 1'b0);
        capture("ps0_nopar", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1, 1'b0);

        // prescale 1 with even parity (^55 = 0)
        start_frame(8'h55, 1'b1, 1'b0, 8'd1, 1'b0);
        capture("ps1_par", {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 1, 1'b0);

        // A5 odd parity (1), P=3; inputs disturbed mid-frame, stray valid dropped
        start_frame(8'hA5, 1'b1, 1'b1, 8'd3, 1'b0);
        capture("a5_midchg", {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 3, 1'b1);
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) bad++;
        end
        check("stray_valid_dropped", 128'(bad), 128'(0));

        // Held data_valid: exactly one idle cycle, then the next start bit
        start_frame(8'h3C, 1'b0, 1'b0, 8'd2, 1'b1);
        capture("hold_first", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 2, 1'b0);
        check("hold_gap_busy", 128'(bus.busy), 128'(0));
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        check("hold_restart_busy", 128'(bus.busy), 128'(1));
        check("hold_restart_tx", 128'(bus.tx_out), 128'(0));
        capture("hold_second", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 2, 1'b0);

        // Reset during data bit 3 (cycles 16..19 of a P=4 frame)
        start_frame(8'hD2, 1'b1, 1'b0, 8'd4, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_bit3", 128'(bus.tx_out), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_tx", 128'(bus.tx_out), 128'(1));
        check("async_reset_busy", 128'(bus.busy), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        bus.p_data = 8'h0F;
        bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) bad++;
        end
        check("post_reset_idle", 128'(bad), 128'(0));

        // Normal operation resumes after reset
        start_frame(8'h81, 1'b1, 1'b0, 8'd2, 1'b0);
        capture("after_reset", {5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
